// File: rtl/clock_monitor_if.sv
// clock_monitor_if
//   Groups the clock monitor's observed clocks, controls and status outputs.
//   The master side drives the derived clocks, clear_fault and period_sel and
//   reads the status. The slave side is the monitor itself.
//
//   imem_clock       derived clock, channel 0
//   dmem_clock       derived clock, channel 1
//   processor_clock  derived clock, channel 2
//   regfile_clock    derived clock, channel 3
//   clear_fault      one-cycle pulse, leaves FAULT and clears err_mask
//   period_sel       channel shown on period_out (0 imem .. 3 regfile)
//   locked           monitor is in LOCKED
//   fault            monitor is in FAULT
//   err_mask         sticky per-channel errors {regfile,processor,dmem,imem}
//   period_out       last measured period of the selected channel
interface clock_monitor_if #(
  parameter int CNT_W = 8
);
  logic             imem_clock;
  logic             dmem_clock;
  logic             processor_clock;
  logic             regfile_clock;
  logic             clear_fault;
  logic [1:0]       period_sel;
  logic             locked;
  logic             fault;
  logic [3:0]       err_mask;
  logic [CNT_W-1:0] period_out;

  modport master (
    output imem_clock, dmem_clock, processor_clock, regfile_clock,
    output clear_fault, period_sel,
    input  locked, fault, err_mask, period_out
  );

  modport slave (
    input  imem_clock, dmem_clock, processor_clock, regfile_clock,
    input  clear_fault, period_sel,
    output locked, fault, err_mask, period_out
  );
endinterface

// File: rtl/clock_monitor.sv
// clock_monitor
//   Watches the four clocks produced by the master-clock divider. Each derived
//   clock is sampled as data in the master clock domain; the distance between
//   its rising edges is measured in master cycles and compared with the
//   expected divide ratio. Reports lock, sticky per-channel errors and a fault
//   state.
//
//   clock  master clock, all logic on the rising edge
//   reset  asynchronous, active-low reset
//   mon    clock_monitor_if slave port (derived clocks, clear_fault,
//          period_sel in; locked, fault, err_mask, period_out out)
module clock_monitor #(
  parameter int IMEM_PERIOD    = 2,
  parameter int DMEM_PERIOD    = 2,
  parameter int PROC_PERIOD    = 4,
  parameter int REGFILE_PERIOD = 2,
  parameter int LOCK_COUNT     = 4,
  parameter int CNT_W          = 8
) (
  input  logic           clock,
  input  logic           reset,
  clock_monitor_if.slave mon
);

  localparam int               GR_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [GR_W-1:0]  GR_FULL = GR_W'(LOCK_COUNT);

  typedef enum logic [1:0] {ST_WAIT, ST_LOCKED, ST_FAULT} state_e;

  function automatic logic [CNT_W-1:0] expPeriod(input int ch);
    case (ch)
      0:       return CNT_W'(IMEM_PERIOD);
      1:       return CNT_W'(DMEM_PERIOD);
      2:       return CNT_W'(PROC_PERIOD);
      default: return CNT_W'(REGFILE_PERIOD);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       clkIn;
  logic [3:0]       prev_q, armed_q, armed_d, rise, errEvt;
  logic [3:0]       errMask_q, errMask_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] period_q [4];
  logic [CNT_W-1:0] period_d [4];
  logic [GR_W-1:0]  goodRun_q [4];
  logic [GR_W-1:0]  goodRun_d [4];
  logic             clearNow;
  logic             allGood;

  assign clkIn    = {mon.regfile_clock, mon.processor_clock,
                     mon.dmem_clock, mon.imem_clock};
  assign clearNow = (state_q == ST_FAULT) && mon.clear_fault;

  // Per-channel measurement. cnt counts master edges since the last rise, so
  // at the next rise it holds exactly the rise-to-rise period. A stall is
  // flagged once, on the edge where that count reaches twice the expected
  // period without a rise; the count keeps moving past it so it cannot refire.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rise[i]      = clkIn[i] & ~prev_q[i];
      errEvt[i]    = 1'b0;
      armed_d[i]   = armed_q[i] | rise[i];
      period_d[i]  = period_q[i];
      goodRun_d[i] = goodRun_q[i];

      if (rise[i])
        cnt_d[i] = CNT_W'(1);
      else if (cnt_q[i] != CNT_MAX)
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else
        cnt_d[i] = cnt_q[i];

      if (armed_q[i] && rise[i]) begin
        period_d[i] = cnt_q[i];
        if (cnt_q[i] == expPeriod(i)) begin
          if (goodRun_q[i] != GR_FULL)
            goodRun_d[i] = goodRun_q[i] + GR_W'(1);
        end else begin
          errEvt[i]    = 1'b1;
          goodRun_d[i] = '0;
        end
      end else if (armed_q[i] && (cnt_q[i] == (expPeriod(i) << 1))) begin
        errEvt[i]    = 1'b1;
        goodRun_d[i] = '0;
      end

      if (clearNow)
        goodRun_d[i] = '0;
    end
  end

  // Errors only become sticky once the clocks have been trusted; clearing a
  // fault takes priority over any error arriving on the same edge.
  always_comb begin
    errMask_d = errMask_q;
    if (clearNow)
      errMask_d = '0;
    else if (state_q != ST_WAIT)
      errMask_d = errMask_q | errEvt;
  end

  // Channel state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q    <= '0;
      armed_q   <= '0;
      errMask_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]     <= '0;
        period_q[i]  <= '0;
        goodRun_q[i] <= '0;
      end
    end else begin
      prev_q    <= clkIn;
      armed_q   <= armed_d;
      errMask_q <= errMask_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]     <= cnt_d[i];
        period_q[i]  <= period_d[i];
        goodRun_q[i] <= goodRun_d[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_q <= ST_WAIT;
    else
      state_q <= state_d;
  end

  // FSM next state. Lock is judged on the registered good-run counts.
  always_comb begin
    allGood = 1'b1;
    for (int i = 0; i < 4; i++)
      if (goodRun_q[i] != GR_FULL)
        allGood = 1'b0;

    state_d = state_q;
    case (state_q)
      ST_WAIT:   if (allGood)         state_d = ST_LOCKED;
      ST_LOCKED: if (errEvt != 4'b0)  state_d = ST_FAULT;
      ST_FAULT:  if (mon.clear_fault) state_d = ST_WAIT;
      default:                        state_d = ST_WAIT;
    endcase
  end

  // FSM outputs and status.
  always_comb begin
    mon.locked     = (state_q == ST_LOCKED);
    mon.fault      = (state_q == ST_FAULT);
    mon.err_mask   = errMask_q;
    mon.period_out = period_q[mon.period_sel];
  end

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor
//   Drives the four derived clocks from software dividers (with optional
//   stuck-high and single-sample glitches) and compares every cycle against a
//   timestamp-based reference of the monitor's rules.
module tb_clock_monitor;

  localparam int CNT_W    = 8;
  localparam int LOCK     = 4;
  localparam int M_WAIT   = 0;
  localparam int M_LOCKED = 1;
  localparam int M_FAULT  = 2;

  int expP [4] = '{2, 2, 4, 2};

  logic clock = 1'b0;
  logic reset = 1'b0;

  clock_monitor_if #(.CNT_W(CNT_W)) monIf ();

  clock_monitor #(
    .IMEM_PERIOD(2), .DMEM_PERIOD(2), .PROC_PERIOD(4), .REGFILE_PERIOD(2),
    .LOCK_COUNT(LOCK), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon  (monIf)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  int         tick;
  int         div  [4];
  int         offs [4];
  bit [3:0]   forceHigh;
  bit [3:0]   glitchNow;
  bit [3:0]   vin;
  logic       clearReq;
  logic [1:0] sel;

  // Reference state: last rise time per channel instead of counters.
  bit [3:0] mPrev;
  bit [3:0] mArmed;
  bit [3:0] mMask;
  int       mLast [4];
  int       mGood [4];
  int       mPer  [4];
  int       mState;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      mLast[i] = 0;
      mGood[i] = 0;
      mPer[i]  = 0;
    end
    mPrev  = '0;
    mArmed = '0;
    mMask  = '0;
    mState = M_WAIT;
    tick   = 0;
  endtask

  task automatic modelEdge();
    bit       allGood;
    bit [3:0] ev;
    int       gap;
    allGood = 1'b1;
    for (int i = 0; i < 4; i++)
      if (mGood[i] != LOCK) allGood = 1'b0;
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      gap = tick - mLast[i];
      if (vin[i] && !mPrev[i]) begin
        if (mArmed[i]) begin
          mPer[i] = (gap > 255) ? 255 : gap;
          if (mPer[i] == expP[i]) begin
            mGood[i] = (mGood[i] < LOCK) ? mGood[i] + 1 : LOCK;
          end else begin
            ev[i]    = 1'b1;
            mGood[i] = 0;
          end
        end
        mArmed[i] = 1'b1;
        mLast[i]  = tick;
      end else if (mArmed[i] && gap == 2 * expP[i]) begin
        ev[i]    = 1'b1;
        mGood[i] = 0;
      end
      mPrev[i] = vin[i];
    end
    case (mState)
      M_WAIT:   if (allGood) mState = M_LOCKED;
      M_LOCKED: begin
        mMask = mMask | ev;
        if (ev != 4'b0) mState = M_FAULT;
      end
      default: begin
        if (clearReq) begin
          mMask = '0;
          for (int i = 0; i < 4; i++) mGood[i] = 0;
          mState = M_WAIT;
        end else begin
          mMask = mMask | ev;
        end
      end
    endcase
    tick++;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (tick %0d)", tag, obs, expv, tick);
    end
  endtask

  task automatic checkOutput();
    checkEq("locked",     32'(monIf.locked),     32'(mState == M_LOCKED));
    checkEq("fault",      32'(monIf.fault),      32'(mState == M_FAULT));
    checkEq("err_mask",   32'(monIf.err_mask),   32'(mMask));
    checkEq("period_out", 32'(monIf.period_out), 32'(mPer[sel]));
  endtask

  // One master cycle: drive at the negedge, let the edge happen, compare at
  // the following negedge.
  task automatic applyStimulus();
    bit base;
    for (int i = 0; i < 4; i++) begin
      base   = (((tick + offs[i]) % div[i]) < (div[i] / 2));
      vin[i] = forceHigh[i] ? 1'b1 : (base ^ glitchNow[i]);
    end
    glitchNow              = '0;
    monIf.imem_clock       = vin[0];
    monIf.dmem_clock       = vin[1];
    monIf.processor_clock  = vin[2];
    monIf.regfile_clock    = vin[3];
    monIf.clear_fault      = clearReq;
    monIf.period_sel       = sel;
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkOutput();
  endtask

  task automatic run(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic doReset();
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      div[i]  = expP[i];
      offs[i] = 0;
    end
    forceHigh = '0;
    glitchNow = '0;
    clearReq  = 1'b0;
    sel       = 2'd0;
    monIf.imem_clock      = 1'b0;
    monIf.dmem_clock      = 1'b0;
    monIf.processor_clock = 1'b0;
    monIf.regfile_clock   = 1'b0;
    monIf.clear_fault     = 1'b0;
    monIf.period_sel      = 2'd0;
    modelReset();

    // Reset state
    #12;
    checkOutput();
    @(negedge clock);
    reset = 1'b1;

    // Nominal dividers from reset
    sel = 2'd2;
    run(30);
    checkEq("nominal_locked", 32'(monIf.locked),     32'd1);
    checkEq("nominal_mask",   32'(monIf.err_mask),   32'd0);
    checkEq("nominal_period", 32'(monIf.period_out), 32'd4);

    // Wrong processor ratio before lock
    doReset();
    div[2] = 3;
    run(30);
    checkEq("ratio_locked", 32'(monIf.locked),     32'd0);
    checkEq("ratio_fault",  32'(monIf.fault),      32'd0);
    checkEq("ratio_mask",   32'(monIf.err_mask),   32'd0);
    checkEq("ratio_period", 32'(monIf.period_out), 32'd3);
    div[2] = 4;

    // Lock, then stick dmem high just after one of its rises
    doReset();
    run(30);
    while (tick % 2 == 0) applyStimulus();
    forceHigh[1] = 1'b1;
    run(6);
    checkEq("stuck_fault",  32'(monIf.fault),    32'd1);
    checkEq("stuck_locked", 32'(monIf.locked),   32'd0);
    checkEq("stuck_mask",   32'(monIf.err_mask), 32'd2);

    // Clear on the same edge as a regfile stall event
    forceHigh[1] = 1'b0;
    run(3);
    while (tick % 2 == 0) applyStimulus();
    forceHigh[3] = 1'b1;
    run(3);
    clearReq = 1'b1;
    applyStimulus();
    clearReq = 1'b0;
    checkEq("clrwin_fault",  32'(monIf.fault),    32'd0);
    checkEq("clrwin_mask",   32'(monIf.err_mask), 32'd0);
    checkEq("clrwin_locked", 32'(monIf.locked),   32'd0);
    forceHigh[3] = 1'b0;
    run(40);
    checkEq("relock_locked", 32'(monIf.locked), 32'd1);

    // imem and regfile glitch together while locked
    while (tick % 2 == 0) applyStimulus();
    glitchNow = 4'b1001;
    applyStimulus();
    run(6);
    checkEq("dual_fault", 32'(monIf.fault),    32'd1);
    checkEq("dual_mask",  32'(monIf.err_mask), 32'h9);

    // Recover, then async reset between edges while locked
    clearReq = 1'b1;
    applyStimulus();
    clearReq = 1'b0;
    run(40);
    checkEq("prereset_locked", 32'(monIf.locked), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkEq("async_locked", 32'(monIf.locked),     32'd0);
    checkEq("async_fault",  32'(monIf.fault),      32'd0);
    checkEq("async_mask",   32'(monIf.err_mask),   32'd0);
    checkEq("async_period", 32'(monIf.period_out), 32'd0);
    modelReset();
    @(negedge clock);
    reset = 1'b1;
    run(3);
    checkEq("first_rise_unmeasured", 32'(monIf.period_out), 32'd0);
    run(2);
    checkEq("second_rise_measured",  32'(monIf.period_out), 32'd4);

    // Randomized segments: offsets, occasional wrong ratios, glitches, clears
    for (int i = 0; i < 4; i++) offs[i] = int'($urandom_range(0, 7));
    for (int seg = 0; seg < 10; seg++) begin
      for (int i = 0; i < 4; i++)
        div[i] = ($urandom_range(0, 7) == 0) ? expP[i] + 1 : expP[i];
      repeat (40) begin
        sel      = 2'($urandom_range(0, 3));
        clearReq = ($urandom_range(0, 15) == 0);
        for (int i = 0; i < 4; i++)
          glitchNow[i] = ($urandom_range(0, 63) == 0);
        applyStimulus();
      end
      clearReq = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a run that never reaches the end of the sequence.
  initial begin
    #1000000;
    bad++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
